spi_ram_burst: RTL and testbench
================================

Name: spi_ram_burst

Overview:
Parametrised command-decoded single-port RAM sitting behind the SPI slave shift logic. Accepts the same 2-bit-opcode frames: set write address, write data, set read address, read. Adds:
- auto-increment on write and read addresses;
- multi-word read bursts;
- a tx_ready backpressure handshake toward the SPI transmit shifter;
- busy and error reporting.

Parameters:
ADDR_W, 8, address width in bits; must be <= DATA_W.
DATA_W, 8, data word width in bits.
MEM_DEPTH, 2**ADDR_W, number of words; addresses wrap modulo MEM_DEPTH.

Ports:
clk  input  1  clock, all logic on rising edge.
rst_n  input  1  reset, asynchronous, active-low.
din  input  DATA_W+2  frame from SPI slave; din[DATA_W+1:DATA_W] opcode, din[DATA_W-1:0] payload.
rx_valid  input  1  din valid for exactly the cycles it is high; one frame per high cycle.
tx_ready  input  1  SPI transmit side can accept dout this cycle.
dout  output  DATA_W  read data word.
tx_valid  output  1  dout holds a valid word not yet accepted.
busy  output  1  high while a read burst is in progress.
cmd_err  output  1  one-cycle pulse when a frame is dropped.

Behaviour:
- Reset (async assert, sync release) clears dout, tx_valid, busy, cmd_err, wr_addr, rd_addr and the burst counter, and forces state IDLE. Memory contents are not reset and are retained across rst_n.
- States: IDLE, SEND. busy = (state == SEND).
- Frames in IDLE, decoded on rx_valid=1:
  - 00: wr_addr <= payload[ADDR_W-1:0].
  - 01: mem[wr_addr] <= payload; wr_addr <= wr_addr+1, wrapping MEM_DEPTH-1 -> 0.
  - 10: rd_addr <= payload[ADDR_W-1:0].
  - 11: burst length N = payload[ADDR_W-1:0], with N=0 treated as 1. Next edge: dout <= mem[rd_addr], tx_valid <= 1, rd_addr <= rd_addr+1 (wrapping), remaining <= N-1, state <= SEND. Latency is 1 clock from the frame to tx_valid.
- SEND:
  - dout and tx_valid hold stable while tx_ready=0.
  - On a cycle with tx_valid=1 and tx_ready=1 (transfer):
    - remaining==0: tx_valid <= 0, state <= IDLE; dout keeps its last value.
    - otherwise: dout <= mem[rd_addr], rd_addr++ (wrapping), remaining--, tx_valid stays 1. This gives back-to-back words at 1 word/clock while tx_ready stays high.
- rx_valid=1 while in SEND: the frame is ignored with no state, address or memory change, and cmd_err pulses high the next cycle.
- An opcode-11 frame with ADDR_W < DATA_W ignores upper payload bits. The same applies to the address payloads of opcodes 00 and 10.
- rd_addr after a burst points one past the last word read, so a following 11 frame continues sequentially.
- Writes never occur while busy, so there is no read/write collision.
- rst_n asserted mid-burst: tx_valid drops immediately (async), the burst is abandoned, addresses go to 0, and memory is unchanged.
- cmd_err is 0 on every cycle except the pulse cycle.

Test Plan:
1. Reset, then frames 00/0x10, 01/0xA5, 10/0x10, 11/0x00 with tx_ready=1 -> one cycle after the 11 frame: dout=0xA5, tx_valid=1 for one cycle, busy 1 then 0.
2. Write 0x11,0x22,0x33,0x44 via 00/0xFE then four 01 frames (wraps to 0x00,0x01); set rd 0xFE, send 11/0x04 with tx_ready=1 -> dout 0x11,0x22,0x33,0x44 on 4 consecutive cycles, then tx_valid=0.
3. Same burst with tx_ready toggling 1,0,0,1,1,0,1 -> each word held stable while tx_ready=0; exactly 4 transfers, in order, with no duplicates.
4. During a busy burst, drive 01/0x77 -> cmd_err pulses once; a later readback of wr_addr's location shows no 0x77 written; the burst output is unaffected.
5. Assert rst_n mid-burst after the second word -> tx_valid=0 and busy=0 immediately; after release, 10/0xFE then 11/0x01 returns 0x11 (memory retained).
6. Two consecutive 11/0x02 frames from rd 0x00 (second sent after busy falls) -> words mem[0],mem[1],mem[2],mem[3] in order.

Source files
------------

// File: rtl/spi_ram_burst.sv
// -----------------------------------------------------------------------------
// spi_ram_burst
//   Command-decoded single-port RAM behind the SPI slave shift logic.
//   Each received frame carries a 2-bit opcode and a payload:
//     00 set write address, 01 write data (auto-increment write address),
//     10 set read address,  11 read burst of N words (N=0 means 1).
//   Read words are presented on dout/tx_valid and advance only when the
//   transmit shifter accepts them (tx_valid & tx_ready), giving up to one
//   word per clock. Frames arriving during a burst are dropped and flagged.
//
// Ports
//   clk       in   clock, all logic on rising edge
//   rst_n     in   asynchronous active-low reset (memory contents retained)
//   din       in   [DATA_W+1:DATA_W] opcode, [DATA_W-1:0] payload
//   rx_valid  in   din holds one frame for each cycle this is high
//   tx_ready  in   transmit side accepts dout this cycle
//   dout      out  read data word
//   tx_valid  out  dout holds a word not yet accepted
//   busy      out  read burst in progress
//   cmd_err   out  one-cycle pulse when a frame was dropped
// -----------------------------------------------------------------------------
module spi_ram_burst #(
    parameter int ADDR_W    = 8,
    parameter int DATA_W    = 8,
    parameter int MEM_DEPTH = 2 ** ADDR_W
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic [DATA_W+1:0] din,
    input  logic              rx_valid,
    input  logic              tx_ready,
    output logic [DATA_W-1:0] dout,
    output logic              tx_valid,
    output logic              busy,
    output logic              cmd_err
);

    localparam logic [1:0] OP_SET_WR = 2'b00;
    localparam logic [1:0] OP_WRITE  = 2'b01;
    localparam logic [1:0] OP_SET_RD = 2'b10;
    localparam logic [1:0] OP_READ   = 2'b11;

    typedef enum logic [0:0] {
        ST_IDLE = 1'b0,
        ST_SEND = 1'b1
    } state_t;

    // Address increment with wrap at the last implemented word, so a
    // non-power-of-two depth still wraps to 0.
    function automatic logic [ADDR_W-1:0] addr_inc(input logic [ADDR_W-1:0] a);
        logic [ADDR_W-1:0] r;
        if (a == ADDR_W'(MEM_DEPTH - 1)) begin
            r = {ADDR_W{1'b0}};
        end else begin
            r = a + ADDR_W'(1);
        end
        return r;
    endfunction

    state_t              state_r;
    state_t              state_nxt_s;

    logic [ADDR_W-1:0]   wr_addr_r;
    logic [ADDR_W-1:0]   rd_addr_r;
    logic [ADDR_W-1:0]   remaining_r;
    logic [DATA_W-1:0]   dout_r;
    logic                tx_valid_r;
    logic                cmd_err_r;

    logic [ADDR_W-1:0]   wr_addr_nxt_s;
    logic [ADDR_W-1:0]   rd_addr_nxt_s;
    logic [ADDR_W-1:0]   remaining_nxt_s;
    logic [DATA_W-1:0]   dout_nxt_s;
    logic                tx_valid_nxt_s;
    logic                cmd_err_nxt_s;
    logic                mem_we_s;

    logic [1:0]          opcode_s;
    logic [DATA_W-1:0]   payload_s;
    logic [ADDR_W-1:0]   payload_addr_s;
    logic [DATA_W-1:0]   mem_rd_s;
    logic                xfer_s;

    logic [DATA_W-1:0]   mem [0:MEM_DEPTH-1];

    assign opcode_s       = din[DATA_W+1:DATA_W];
    assign payload_s      = din[DATA_W-1:0];
    // Address and burst-length payloads use only the low ADDR_W bits.
    assign payload_addr_s = din[ADDR_W-1:0];
    assign mem_rd_s       = mem[rd_addr_r];
    assign xfer_s         = tx_valid_r & tx_ready;

    // State register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r <= ST_IDLE;
        end else begin
            state_r <= state_nxt_s;
        end
    end

    // Next-state decode: enter SEND on a read frame, leave after the last transfer.
    always_comb begin
        state_nxt_s = state_r;
        case (state_r)
            ST_IDLE: begin
                if (rx_valid && (opcode_s == OP_READ)) begin
                    state_nxt_s = ST_SEND;
                end else begin
                    state_nxt_s = ST_IDLE;
                end
            end
            ST_SEND: begin
                if (xfer_s && (remaining_r == {ADDR_W{1'b0}})) begin
                    state_nxt_s = ST_IDLE;
                end else begin
                    state_nxt_s = ST_SEND;
                end
            end
            default: begin
                state_nxt_s = ST_IDLE;
            end
        endcase
    end

    // Output/datapath decode: next values of every registered output and address.
    always_comb begin
        wr_addr_nxt_s   = wr_addr_r;
        rd_addr_nxt_s   = rd_addr_r;
        remaining_nxt_s = remaining_r;
        dout_nxt_s      = dout_r;
        tx_valid_nxt_s  = tx_valid_r;
        cmd_err_nxt_s   = 1'b0;
        mem_we_s        = 1'b0;
        case (state_r)
            ST_IDLE: begin
                if (rx_valid) begin
                    case (opcode_s)
                        OP_SET_WR: begin
                            wr_addr_nxt_s = payload_addr_s;
                        end
                        OP_WRITE: begin
                            mem_we_s      = 1'b1;
                            wr_addr_nxt_s = addr_inc(wr_addr_r);
                        end
                        OP_SET_RD: begin
                            rd_addr_nxt_s = payload_addr_s;
                        end
                        OP_READ: begin
                            dout_nxt_s     = mem_rd_s;
                            tx_valid_nxt_s = 1'b1;
                            rd_addr_nxt_s  = addr_inc(rd_addr_r);
                            // A zero length is a one-word burst.
                            if (payload_addr_s == {ADDR_W{1'b0}}) begin
                                remaining_nxt_s = {ADDR_W{1'b0}};
                            end else begin
                                remaining_nxt_s = payload_addr_s - ADDR_W'(1);
                            end
                        end
                        default: begin
                            wr_addr_nxt_s = wr_addr_r;
                        end
                    endcase
                end else begin
                    tx_valid_nxt_s = 1'b0;
                end
            end
            ST_SEND: begin
                // Any frame during a burst is dropped and flagged next cycle.
                cmd_err_nxt_s = rx_valid;
                if (xfer_s) begin
                    if (remaining_r == {ADDR_W{1'b0}}) begin
                        // Last word taken; dout keeps the final value.
                        tx_valid_nxt_s = 1'b0;
                    end else begin
                        dout_nxt_s      = mem_rd_s;
                        tx_valid_nxt_s  = 1'b1;
                        rd_addr_nxt_s   = addr_inc(rd_addr_r);
                        remaining_nxt_s = remaining_r - ADDR_W'(1);
                    end
                end else begin
                    // Hold the offered word until the shifter accepts it.
                    tx_valid_nxt_s = tx_valid_r;
                end
            end
            default: begin
                tx_valid_nxt_s = 1'b0;
            end
        endcase
    end

    // Datapath registers; cleared asynchronously by rst_n.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_addr_r   <= {ADDR_W{1'b0}};
            rd_addr_r   <= {ADDR_W{1'b0}};
            remaining_r <= {ADDR_W{1'b0}};
            dout_r      <= {DATA_W{1'b0}};
            tx_valid_r  <= 1'b0;
            cmd_err_r   <= 1'b0;
        end else begin
            wr_addr_r   <= wr_addr_nxt_s;
            rd_addr_r   <= rd_addr_nxt_s;
            remaining_r <= remaining_nxt_s;
            dout_r      <= dout_nxt_s;
            tx_valid_r  <= tx_valid_nxt_s;
            cmd_err_r   <= cmd_err_nxt_s;
        end
    end

    // Memory write port; contents deliberately survive reset.
    always_ff @(posedge clk) begin
        if (mem_we_s) begin
            mem[wr_addr_r] <= payload_s;
        end
    end

    assign dout     = dout_r;
    assign tx_valid = tx_valid_r;
    assign busy     = (state_r == ST_SEND);
    assign cmd_err  = cmd_err_r;

endmodule

// File: tb/tb_spi_ram_burst.sv
// -----------------------------------------------------------------------------
// tb_spi_ram_burst
//   Directed self-checking bench for spi_ram_burst (ADDR_W=DATA_W=8).
//   Inputs change and outputs are sampled on the falling clock edge.
// -----------------------------------------------------------------------------
module tb_spi_ram_burst;

    logic       clk;
    logic       rst_n;
    logic [9:0] din;
    logic       rx_valid;
    logic       tx_ready;
    logic [7:0] dout;
    logic       tx_valid;
    logic       busy;
    logic       cmd_err;

    int n_vec;
    int n_err;

    spi_ram_burst #(.ADDR_W(8), .DATA_W(8)) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .din      (din),
        .rx_valid (rx_valid),
        .tx_ready (tx_ready),
        .dout     (dout),
        .tx_valid (tx_valid),
        .busy     (busy),
        .cmd_err  (cmd_err)
    );

    // 10 ns clock.
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Single comparison point.
    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    // One frame for one clock; returns on the next falling edge.
    task automatic frame(input logic [1:0] op, input logic [7:0] pl);
        din      = {op, pl};
        rx_valid = 1'b1;
        @(negedge clk);
        rx_valid = 1'b0;
        din      = 10'h000;
    endtask

    // Single-word read of addr with tx_ready held high.
    task automatic read_one(input string tag, input logic [7:0] addr, input logic [7:0] exp);
        tx_ready = 1'b1;
        frame(2'b10, addr);
        frame(2'b11, 8'h01);
        check_eq({tag, "_valid"}, 32'(tx_valid), 32'd1);
        check_eq({tag, "_data"},  32'(dout),     32'(exp));
        @(negedge clk);
        check_eq({tag, "_done"},  32'(tx_valid), 32'd0);
    endtask

    logic [7:0] burst_exp [4];
    logic       rdy_pat   [7];
    int         idx;

    initial begin
        n_vec    = 0;
        n_err    = 0;
        rst_n    = 1'b0;
        din      = 10'h000;
        rx_valid = 1'b0;
        tx_ready = 1'b0;
        burst_exp[0] = 8'h11; burst_exp[1] = 8'h22;
        burst_exp[2] = 8'h33; burst_exp[3] = 8'h44;
        rdy_pat[0] = 1'b1; rdy_pat[1] = 1'b0; rdy_pat[2] = 1'b0; rdy_pat[3] = 1'b1;
        rdy_pat[4] = 1'b1; rdy_pat[5] = 1'b0; rdy_pat[6] = 1'b1;

        repeat (2) @(negedge clk);
        check_eq("rst_dout",  32'(dout),     32'd0);
        check_eq("rst_valid", 32'(tx_valid), 32'd0);
        check_eq("rst_busy",  32'(busy),     32'd0);
        check_eq("rst_err",   32'(cmd_err),  32'd0);
        rst_n = 1'b1;
        @(negedge clk);

        // 1: single write/read, zero length means one word.
        tx_ready = 1'b1;
        frame(2'b00, 8'h10);
        frame(2'b01, 8'hA5);
        frame(2'b10, 8'h10);
        frame(2'b11, 8'h00);
        check_eq("t1_valid", 32'(tx_valid), 32'd1);
        check_eq("t1_dout",  32'(dout),     32'hA5);
        check_eq("t1_busy",  32'(busy),     32'd1);
        @(negedge clk);
        check_eq("t1_valid_end", 32'(tx_valid), 32'd0);
        check_eq("t1_busy_end",  32'(busy),     32'd0);
        check_eq("t1_dout_keep", 32'(dout),     32'hA5);

        // 2: writes wrap FE,FF,00,01; full-rate burst reads them back.
        frame(2'b00, 8'hFE);
        frame(2'b01, 8'h11);
        frame(2'b01, 8'h22);
        frame(2'b01, 8'h33);
        frame(2'b01, 8'h44);
        frame(2'b10, 8'hFE);
        frame(2'b11, 8'h04);
        for (int i = 0; i < 4; i++) begin
            check_eq("t2_valid", 32'(tx_valid), 32'd1);
            check_eq("t2_dout",  32'(dout),     32'(burst_exp[i]));
            @(negedge clk);
        end
        check_eq("t2_valid_end", 32'(tx_valid), 32'd0);
        check_eq("t2_busy_end",  32'(busy),     32'd0);

        // 3: same burst under backpressure.
        frame(2'b10, 8'hFE);
        frame(2'b11, 8'h04);
        idx = 0;
        for (int k = 0; k < 7; k++) begin
            tx_ready = rdy_pat[k];
            check_eq("t3_valid", 32'(tx_valid), 32'd1);
            check_eq("t3_dout",  32'(dout),     32'(burst_exp[idx]));
            if (rdy_pat[k]) idx++;
            @(negedge clk);
        end
        check_eq("t3_valid_end", 32'(tx_valid), 32'd0);
        check_eq("t3_busy_end",  32'(busy),     32'd0);

        // 4: frame during a burst is dropped.
        tx_ready = 1'b1;
        frame(2'b00, 8'h02);
        frame(2'b01, 8'h5A);
        frame(2'b01, 8'h66);
        frame(2'b00, 8'h03);
        tx_ready = 1'b0;
        frame(2'b10, 8'hFE);
        frame(2'b11, 8'h04);
        frame(2'b01, 8'h77);
        check_eq("t4_err",   32'(cmd_err),  32'd1);
        check_eq("t4_dout",  32'(dout),     32'h11);
        check_eq("t4_valid", 32'(tx_valid), 32'd1);
        @(negedge clk);
        check_eq("t4_err_end", 32'(cmd_err), 32'd0);
        tx_ready = 1'b1;
        for (int i = 0; i < 4; i++) begin
            check_eq("t4_burst", 32'(dout), 32'(burst_exp[i]));
            @(negedge clk);
        end
        check_eq("t4_valid_end", 32'(tx_valid), 32'd0);
        read_one("t4_nowrite", 8'h03, 8'h66);
        // wr_addr must still be 03.
        frame(2'b01, 8'hC3);
        read_one("t4_wraddr", 8'h03, 8'hC3);

        // 5: reset mid-burst.
        frame(2'b10, 8'hFE);
        frame(2'b11, 8'h04);
        check_eq("t5_w0", 32'(dout), 32'h11);
        @(negedge clk);
        check_eq("t5_w1", 32'(dout), 32'h22);
        rst_n = 1'b0;
        #1;
        check_eq("t5_rst_valid", 32'(tx_valid), 32'd0);
        check_eq("t5_rst_busy",  32'(busy),     32'd0);
        check_eq("t5_rst_dout",  32'(dout),     32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        // rd_addr cleared to 0: mem[0] = 0x33.
        frame(2'b11, 8'h01);
        check_eq("t5_rdaddr0", 32'(dout), 32'h33);
        @(negedge clk);
        read_one("t5_retain", 8'hFE, 8'h11);

        // 6: consecutive bursts continue sequentially.
        frame(2'b10, 8'h00);
        frame(2'b11, 8'h02);
        check_eq("t6_w0", 32'(dout), 32'h33);
        @(negedge clk);
        check_eq("t6_w1", 32'(dout), 32'h44);
        @(negedge clk);
        check_eq("t6_busy_gap", 32'(busy), 32'd0);
        frame(2'b11, 8'h02);
        check_eq("t6_w2", 32'(dout), 32'h5A);
        @(negedge clk);
        check_eq("t6_w3", 32'(dout), 32'hC3);
        @(negedge clk);
        check_eq("t6_valid_end", 32'(tx_valid), 32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
